paralelo_serial_tx: RTL and testbench

- Transmit end of the 2-bit serial link at 16f.
- Accepts 8-bit words plus a valid bit from the upstream (mux) stage and buffers them in a small FIFO.
- Serialises each byte MSB-first as four 2-bit symbols, one per clk16.
- Sends the comma 8'hBC for start-up synchronisation and as idle fill, so the serial-to-parallel receiver can lock and flag data valid.

---
 rtl/paralelo_serial_tx_if.sv | 11 +
 rtl/paralelo_serial_tx.sv | 127 ++++++++++++
 tb/tb_paralelo_serial_tx.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/paralelo_serial_tx_if.sv
// rtl/paralelo_serial_tx_if.sv - parallel-in / serial-out link signal bundle
interface paralelo_serial_tx_if;
  logic [8:0] inParalelo;
  logic [1:0] serial;
  logic       fifo_full;
  logic       overflow;
  logic       sync_done;

  modport master (output inParalelo, input serial, fifo_full, overflow, sync_done);
  modport slave  (input inParalelo, output serial, fifo_full, overflow, sync_done);
endinterface

// File: rtl/paralelo_serial_tx.sv
// rtl/paralelo_serial_tx.sv - byte FIFO feeding a 2-bit MSB-first serialiser with comma sync/idle fill
module paralelo_serial_tx #(
  parameter int          DEPTH       = 4,
  parameter int          SYNC_COMMAS = 4,
  parameter logic [7:0]  COMMA       = 8'hBC
) (
  input  logic                 clk16,
  input  logic                 reset16,
  paralelo_serial_tx_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SYN_W = $clog2(SYNC_COMMAS + 2);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [SYN_W-1:0] SYNC_C  = SYN_W'(SYNC_COMMAS);

  logic [1:0]       fase_q, fase_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [1:0]       serial_q, serial_d;
  logic [SYN_W-1:0] sync_cnt_q, sync_cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             overflow_q, overflow_d;
  logic             sync_done_q, sync_done_d;
  logic [7:0]       mem_q [DEPTH];

  logic             boundary;
  logic             in_sync;
  logic             wr_req;
  logic             wr_ok;
  logic             pop;
  logic [7:0]       next_byte;

  always_comb begin
    fase_d      = fase_q + 2'd1;
    shreg_d     = shreg_q;
    serial_d    = serial_q;
    sync_cnt_d  = sync_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    sync_done_d = sync_done_q;
    next_byte   = COMMA;

    boundary = (fase_q == 2'd0);
    in_sync  = (sync_cnt_q < SYNC_C);
    wr_req   = bus.inParalelo[8];
    // Fullness is judged on the pre-edge count, so a same-edge pop never frees room.
    wr_ok    = wr_req && (count_q < DEPTH_C);
    pop      = boundary && !in_sync && (count_q != '0);

    if (pop) begin
      next_byte = mem_q[rd_ptr_q];
    end

    case (fase_q)
      2'd0: begin
        shreg_d  = next_byte;
        serial_d = next_byte[7:6];
      end
      2'd1:    serial_d = shreg_q[5:4];
      2'd2:    serial_d = shreg_q[3:2];
      default: serial_d = shreg_q[1:0];
    endcase

    if (boundary && in_sync) begin
      sync_cnt_d = sync_cnt_q + SYN_W'(1);
    end
    sync_done_d = sync_done_q | (sync_cnt_d == SYNC_C);

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({wr_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    full_d     = (count_d == DEPTH_C);
    overflow_d = overflow_q | (wr_req && !wr_ok);
  end

  always_ff @(posedge clk16) begin
    if (!reset16) begin
      fase_q      <= 2'd0;
      shreg_q     <= 8'h00;
      serial_q    <= 2'b00;
      sync_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      sync_done_q <= 1'b0;
    end else begin
      fase_q      <= fase_d;
      shreg_q     <= shreg_d;
      serial_q    <= serial_d;
      sync_cnt_q  <= sync_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      sync_done_q <= sync_done_d;
    end
  end

  // Storage needs no reset; emptiness is carried by the pointers and count.
  always_ff @(posedge clk16) begin
    if (reset16 && wr_ok) begin
      mem_q[wr_ptr_q] <= bus.inParalelo[7:0];
    end
  end

  assign bus.serial    = serial_q;
  assign bus.fifo_full = full_q;
  assign bus.overflow  = overflow_q;
  assign bus.sync_done = sync_done_q;
endmodule

// File: tb/tb_paralelo_serial_tx.sv
// tb/tb_paralelo_serial_tx.sv - scoreboard bench for paralelo_serial_tx
module tb_paralelo_serial_tx;
  localparam int         DEPTH       = 4;
  localparam int         SYNC_COMMAS = 4;
  localparam logic [7:0] COMMA       = 8'hBC;

  typedef struct packed {
    logic [1:0] ser;
    logic       full;
    logic       ovf;
    logic       sync;
  } rec_t;

  logic clk16;
  logic reset16;
  paralelo_serial_tx_if ifc();

  paralelo_serial_tx #(.DEPTH(DEPTH), .SYNC_COMMAS(SYNC_COMMAS), .COMMA(COMMA)) dut (
    .clk16   (clk16),
    .reset16 (reset16),
    .bus     (ifc)
  );

  initial clk16 = 1'b0;
  always #5 clk16 = ~clk16;

  int checks = 0;
  int errors = 0;

  // Reference: a byte queue for the FIFO and a symbol queue for what is still to go on the wire.
  logic [7:0] fifo_m [$];
  logic [1:0] sym_m  [$];
  rec_t       exp_q  [$];
  int         k = 0;
  int         commas = 0;
  logic       ovf_m = 1'b0;
  logic [7:0] b_m;
  rec_t       r_m;

  always @(posedge clk16) begin
    if (!reset16) begin
      fifo_m.delete();
      sym_m.delete();
      k      = 0;
      commas = 0;
      ovf_m  = 1'b0;
      r_m    = '{ser: 2'b00, full: 1'b0, ovf: 1'b0, sync: 1'b0};
      exp_q.push_back(r_m);
    end else begin
      int pre;
      pre = fifo_m.size();
      if (k % 4 == 0) begin
        if (commas < SYNC_COMMAS) begin
          b_m = COMMA;
          commas++;
        end else if (pre > 0) begin
          b_m = fifo_m.pop_front();
        end else begin
          b_m = COMMA;
        end
        for (int i = 3; i >= 0; i--) sym_m.push_back(b_m[2*i +: 2]);
      end
      if (ifc.inParalelo[8]) begin
        if (pre < DEPTH) fifo_m.push_back(ifc.inParalelo[7:0]);
        else             ovf_m = 1'b1;
      end
      k++;
      r_m.ser  = sym_m.pop_front();
      r_m.full = (fifo_m.size() == DEPTH);
      r_m.ovf  = ovf_m;
      r_m.sync = (commas >= SYNC_COMMAS);
      exp_q.push_back(r_m);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk16) begin
    if (exp_q.size() > 0) begin
      rec_t r;
      r = exp_q.pop_front();
      chk("serial",    int'(ifc.serial),    int'(r.ser));
      chk("fifo_full", int'(ifc.fifo_full), int'(r.full));
      chk("overflow",  int'(ifc.overflow),  int'(r.ovf));
      chk("sync_done", int'(ifc.sync_done), int'(r.sync));
    end
  end

  task automatic step(input logic v, input logic [7:0] d);
    ifc.inParalelo = {v, d};
    @(posedge clk16);
    #2;
    ifc.inParalelo = 9'h000;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic do_reset(input int n);
    reset16 = 1'b0;
    idle(n);
    reset16 = 1'b1;
  endtask

  task automatic align(input int ph);
    for (int i = 0; i < 4 && (k % 4) != ph; i++) step(1'b0, 8'h00);
  endtask

  initial begin
    reset16        = 1'b0;
    ifc.inParalelo = 9'h000;
    idle(2);
    reset16 = 1'b1;
    idle(20);

    do_reset(2);
    step(1'b0, 8'h00);
    step(1'b1, 8'hA5);
    idle(24);

    do_reset(2);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h11 + i));
    idle(40);

    // Fill to full from an empty boundary, then write on the next popping boundary.
    do_reset(2);
    idle(20);
    align(0);
    step(1'b1, 8'h31);
    step(1'b1, 8'h32);
    step(1'b1, 8'h33);
    step(1'b1, 8'h34);
    step(1'b1, 8'h77);
    idle(30);

    // Mid-byte reset while 0xA5 is being shifted out.
    align(3);
    step(1'b1, 8'hA5);
    idle(2);
    reset16 = 1'b0;
    idle(1);
    reset16 = 1'b1;
    idle(24);

    for (int c = 0; c < 800; c++) begin
      int p;
      p = (c < 400) ? 70 : 20;
      reset16 = ($urandom_range(0, 249) != 0);
      step($urandom_range(0, 99) < p, 8'($urandom));
    end
    reset16 = 1'b1;
    idle(4);

    @(negedge clk16);
    #1;
    chk("drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
